// File: rtl/spi_cache_pkg.sv
// Shared types for the cache-side SRAM bus initiators.
package spi_cache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [3:0]  SRAM_BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } burst_state_e;

  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
  } obi_req_t;

endpackage

// File: rtl/obi_burst_master.sv
// Burst initiator for the SRAM req/gnt/rvalid port: splits one burst command into
// single-word transactions, streams write data in and read data out.
module obi_burst_master
  import spi_cache_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned LEN_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic              cmd_we_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rdata_valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              sram_req_o,
  input  logic              sram_gnt_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic              sram_rvalid_i,
  input  logic [DATA_W-1:0] sram_rdata_i,
  input  logic              illegal_memory_i
);

  localparam int unsigned OUTST_W = $clog2(MAX_OUTST + 1);

  burst_state_e      state_q, state_d;
  obi_req_t          obi_q, obi_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  loaded_q, loaded_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic              staged_q, staged_d;
  logic              err_q, err_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              wdata_ready_q, wdata_ready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_out_q, err_out_d;

  logic accept, wload, gnt, rsp;

  assign accept = cmd_valid_i & cmd_ready_q;
  assign wload  = wdata_valid_i & wdata_ready_q;
  assign gnt    = obi_q.req & sram_gnt_i;
  // Responses with nothing outstanding are leftovers from before a reset.
  assign rsp    = sram_rvalid_i & (outst_q != '0);

  always_comb begin
    state_d   = state_q;
    obi_d     = obi_q;
    obi_d.be  = SRAM_BE_FULL;
    len_d     = len_q;
    issued_d  = issued_q;
    loaded_d  = loaded_q;
    outst_d   = outst_q;
    staged_d  = staged_q;
    err_d     = err_q;

    if (accept) begin
      len_d      = cmd_len_i;
      issued_d   = '0;
      loaded_d   = '0;
      staged_d   = 1'b0;
      err_d      = 1'b0;
      obi_d.addr = cmd_addr_i & ~ADDR_W'(3);
      obi_d.we   = cmd_we_i;
    end
    if (wload) begin
      obi_d.wdata = wdata_i;
      staged_d    = 1'b1;
      loaded_d    = loaded_q + LEN_W'(1);
    end
    if (gnt) begin
      issued_d   = issued_q + LEN_W'(1);
      obi_d.addr = obi_q.addr + ADDR_W'(4);
      staged_d   = 1'b0;
    end
    if (gnt && !rsp) begin
      outst_d = outst_q + OUTST_W'(1);
    end else if (!gnt && rsp) begin
      outst_d = outst_q - OUTST_W'(1);
    end
    if (rsp && illegal_memory_i) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE:    if (accept) state_d = (cmd_len_i == '0) ? DONE : ISSUE;
      ISSUE:   if (gnt && (issued_d == len_q)) state_d = (outst_d == '0) ? DONE : DRAIN;
      DRAIN:   if (outst_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An ungranted request is held; a new one is raised only when the next cycle may issue.
    obi_d.req = (obi_q.req & ~sram_gnt_i)
              | ((state_d == ISSUE) && (issued_d < len_d) &&
                 (outst_d < OUTST_W'(MAX_OUTST)) && (!obi_d.we || staged_d));

    cmd_ready_d   = (state_d == IDLE);
    wdata_ready_d = (state_d == ISSUE) && obi_d.we && !staged_d && (loaded_d < len_d);
    rvalid_d      = rsp && !obi_q.we;
    rdata_d       = rvalid_d ? sram_rdata_i : rdata_q;
    done_d        = (state_q == DONE);
    err_out_d     = (state_q == DONE) && err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      obi_q         <= '{req: 1'b0, addr: '0, we: 1'b0, be: SRAM_BE_FULL, wdata: '0};
      len_q         <= '0;
      issued_q      <= '0;
      loaded_q      <= '0;
      outst_q       <= '0;
      staged_q      <= 1'b0;
      err_q         <= 1'b0;
      cmd_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      done_q        <= 1'b0;
      err_out_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      obi_q         <= obi_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      loaded_q      <= loaded_d;
      outst_q       <= outst_d;
      staged_q      <= staged_d;
      err_q         <= err_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      done_q        <= done_d;
      err_out_q     <= err_out_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign wdata_ready_o = wdata_ready_q;
  assign rdata_valid_o = rvalid_q;
  assign rdata_o       = rdata_q;
  assign done_o        = done_q;
  assign err_o         = err_out_q;
  assign sram_req_o    = obi_q.req;
  assign sram_addr_o   = obi_q.addr;
  assign sram_we_o     = obi_q.we;
  assign sram_be_o     = obi_q.be;
  assign sram_wdata_o  = obi_q.wdata;

endmodule

// File: tb/tb_obi_burst_master.sv
// Bench for obi_burst_master: behavioural SRAM port with programmable grant/response
// delays, and a burst-level reference of expected addresses, data and error.
module tb_obi_burst_master;

  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned LEN_W     = 8;

  logic              clk_i;
  logic              rst_i;
  logic              cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0]       cmd_addr_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic              wdata_valid_i, wdata_ready_o;
  logic [31:0]       wdata_i;
  logic              rdata_valid_o, done_o, err_o;
  logic [31:0]       rdata_o;
  logic              sram_req_o, sram_gnt_i, sram_we_o, sram_rvalid_i, illegal_memory_i;
  logic [31:0]       sram_addr_o, sram_wdata_o, sram_rdata_i;
  logic [3:0]        sram_be_o;

  obi_burst_master #(.MAX_OUTST(MAX_OUTST), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
    .sram_req_o(sram_req_o), .sram_gnt_i(sram_gnt_i), .sram_addr_o(sram_addr_o),
    .sram_we_o(sram_we_o), .sram_be_o(sram_be_o), .sram_wdata_o(sram_wdata_o),
    .sram_rvalid_i(sram_rvalid_i), .sram_rdata_i(sram_rdata_i),
    .illegal_memory_i(illegal_memory_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        illegal;
    logic        we;
    bit          live;
    int          ready;
  } rsp_t;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  logic [31:0] dev_mem [1024];
  logic [31:0] ref_mem [1024];
  rsp_t        rq[$];
  logic [31:0] exp_addr[$], exp_wd[$], exp_rd[$], wq[$];

  int gnt_wait_max, lat_min, lat_max, wgap_pct, wait_cnt;
  bit fixed_wait, waiting, cur_we, rd_pulse_due, prev_hold, prev_we;
  logic [31:0] prev_addr, prev_wdata;
  int done_cnt, done_cycle, req_seen, rdv_seen, acc_cycle;
  logic done_err, done_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return a[31:12] == 20'h0;
  endfunction

  // One clock: sample outputs at the falling edge, then drive the SRAM side and write stream.
  task automatic tick();
    rsp_t r;
    int   lat;
    logic [31:0] a;
    @(negedge clk_i);
    cycle++;
    if (rd_pulse_due || rdata_valid_o === 1'b1)
      check("rdata_valid_timing", 32'(rdata_valid_o), 32'(rd_pulse_due));
    if (rdata_valid_o === 1'b1) begin
      rdv_seen++;
      check("rdata_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) check("rdata", rdata_o, exp_rd.pop_front());
    end
    if (done_o === 1'b1) begin
      done_cnt++;
      done_cycle = cycle;
      done_err   = err_o;
      done_rdy   = cmd_ready_o;
    end
    if (sram_req_o === 1'b1) req_seen++;
    if (prev_hold) begin
      check("req_held", 32'(sram_req_o), 32'd1);
      check("addr_held", sram_addr_o, prev_addr);
      check("wdata_held", sram_wdata_o, prev_wdata);
      check("we_held", 32'(sram_we_o), 32'(prev_we));
    end

    rd_pulse_due     = 1'b0;
    sram_rvalid_i    = 1'b0;
    sram_rdata_i     = $urandom;
    illegal_memory_i = 1'($urandom_range(0, 1));
    if (rq.size() != 0 && rq[0].ready <= cycle) begin
      r = rq.pop_front();
      sram_rvalid_i    = 1'b1;
      sram_rdata_i     = r.data;
      illegal_memory_i = r.illegal;
      rd_pulse_due     = r.live && !r.we;
    end

    sram_gnt_i = 1'b0;
    if (sram_req_o === 1'b1) begin
      if (!waiting) begin
        waiting  = 1'b1;
        wait_cnt = fixed_wait ? gnt_wait_max : $urandom_range(0, gnt_wait_max);
      end
      if (wait_cnt == 0) begin
        sram_gnt_i = 1'b1;
        waiting    = 1'b0;
        a          = sram_addr_o;
        check("gnt_expected", 32'(exp_addr.size() != 0), 32'd1);
        if (exp_addr.size() != 0) check("addr", a, exp_addr.pop_front());
        check("be", 32'(sram_be_o), 32'hF);
        check("we", 32'(sram_we_o), 32'(cur_we));
        if (sram_we_o === 1'b1) begin
          if (exp_wd.size() != 0) check("wdata", sram_wdata_o, exp_wd.pop_front());
          if (legal(a)) dev_mem[a[11:2]] = sram_wdata_o;
        end
        r.data    = legal(a) ? dev_mem[a[11:2]] : 32'hDEADBEEF;
        r.illegal = !legal(a);
        r.we      = sram_we_o;
        r.live    = 1'b1;
        lat       = $urandom_range(lat_min, lat_max);
        r.ready   = cycle + lat;
        if (rq.size() != 0 && rq[$].ready > r.ready) r.ready = rq[$].ready;
        rq.push_back(r);
        check("outstanding", 32'(rq.size() <= int'(MAX_OUTST)), 32'd1);
      end else begin
        wait_cnt--;
      end
    end
    prev_hold  = (sram_req_o === 1'b1) && !sram_gnt_i;
    prev_addr  = sram_addr_o;
    prev_wdata = sram_wdata_o;
    prev_we    = sram_we_o;

    wdata_valid_i = (wq.size() != 0) && ($urandom_range(0, 99) >= wgap_pct);
    wdata_i       = $urandom;
    if (wq.size() != 0) wdata_i = wq[0];
    if (wdata_valid_i && wdata_ready_o === 1'b1) void'(wq.pop_front());
  endtask

  task automatic issue_cmd(input logic [31:0] base, input int len, input bit we, input bit seq);
    logic [31:0] a, d;
    for (int k = 0; k < len; k++) begin
      a = base + 32'(4 * k);
      exp_addr.push_back(a);
      if (we) begin
        d = seq ? 32'(k + 1) : $urandom;
        wq.push_back(d);
        exp_wd.push_back(d);
        if (legal(a)) ref_mem[a[11:2]] = d;
      end else begin
        exp_rd.push_back(legal(a) ? ref_mem[a[11:2]] : 32'hDEADBEEF);
      end
    end
    cur_we      = we;
    done_cnt    = 0;
    req_seen    = 0;
    cmd_addr_i  = base | 32'($urandom_range(0, 3));
    cmd_we_i    = we;
    cmd_len_i   = LEN_W'(len);
    cmd_valid_i = 1'b1;
    acc_cycle   = -1;
    for (int i = 0; i < 50 && acc_cycle < 0; i++) begin
      if (cmd_ready_o === 1'b1) acc_cycle = cycle;
      tick();
    end
    cmd_valid_i = 1'b0;
    check("cmd_accepted", 32'(acc_cycle >= 0), 32'd1);
  endtask

  task automatic run_burst(input logic [31:0] base, input int len, input bit we,
                           input bit seq, input logic exp_err, input int lat_exp);
    issue_cmd(base, len, we, seq);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
    check("done_seen", 32'(done_cnt), 32'd1);
    if (done_cnt != 0) begin
      check("err", 32'(done_err), 32'(exp_err));
      check("ready_at_done", 32'(done_rdy), 32'd1);
      if (lat_exp > 0) check("done_latency", 32'(done_cycle - acc_cycle), 32'(lat_exp));
    end
    check("all_granted", 32'(exp_addr.size()), 32'd0);
    check("all_read", 32'(exp_rd.size()), 32'd0);
    check("all_wdata_taken", 32'(wq.size()), 32'd0);
    if (len == 0) check("no_req", 32'(req_seen), 32'd0);
    tick();
    check("single_done", 32'(done_cnt), 32'd1);
  endtask

  task automatic set_port(input int gw, input bit fixed, input int lmin, input int lmax, input int gap);
    gnt_wait_max = gw;
    fixed_wait   = fixed;
    lat_min      = lmin;
    lat_max      = lmax;
    wgap_pct     = gap;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    logic        e;
    int          len;
    bit          we;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_we_i = 1'b0; cmd_len_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0;
    sram_gnt_i = 1'b0; sram_rvalid_i = 1'b0; sram_rdata_i = '0; illegal_memory_i = 1'b0;
    waiting = 1'b0; wait_cnt = 0; rd_pulse_due = 1'b0; prev_hold = 1'b0; cur_we = 1'b0;
    done_cnt = 0; req_seen = 0; rdv_seen = 0;
    set_port(0, 1'b1, 1, 1, 0);
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      ref_mem[i] = dev_mem[i];
    end

    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_req", 32'(sram_req_o), 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_wdata_ready", 32'(wdata_ready_o), 32'd0);
    check("rst_addr", sram_addr_o, 32'd0);
    check("rst_wdata", sram_wdata_o, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // Zero-wait port: write 1..4 at 0x10, read it back, then an empty burst.
    run_burst(32'h10, 4, 1'b1, 1'b1, 1'b0, 0);
    run_burst(32'h10, 4, 1'b0, 1'b0, 1'b0, 7);
    run_burst(32'h40, 0, 1'b0, 1'b0, 1'b0, 2);

    // Grant withheld three cycles per request.
    set_port(3, 1'b1, 1, 2, 0);
    run_burst(32'h100, 5, 1'b1, 1'b0, 1'b0, 0);
    run_burst(32'h100, 5, 1'b0, 1'b0, 1'b0, 0);

    // Error responses and 32-bit address wrap.
    set_port(1, 1'b0, 1, 3, 30);
    run_burst(32'hFF8, 4, 1'b0, 1'b0, 1'b1, 0);
    run_burst(32'hFFFF_FFF8, 4, 1'b1, 1'b0, 1'b1, 0);
    run_burst(32'h0, 2, 1'b0, 1'b0, 1'b0, 0);

    // Reset while one read response is still outstanding.
    set_port(2, 1'b1, 4, 4, 0);
    issue_cmd(32'h80, 4, 1'b0, 1'b0);
    for (int i = 0; i < 10 && rq.size() == 0; i++) tick();
    tick();
    check("one_pending", 32'(rq.size()), 32'd1);
    rst_i = 1'b1;
    foreach (rq[i]) rq[i].live = 1'b0;
    exp_addr.delete(); exp_rd.delete();
    prev_hold = 1'b0;
    tick();
    rst_i = 1'b0;
    waiting = 1'b0;
    check("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("mid_rst_req", 32'(sram_req_o), 32'd0);
    rdv_seen = 0;
    done_cnt = 0;
    repeat (8) tick();
    check("stale_rsp_delivered", 32'(rq.size()), 32'd0);
    check("stale_no_rdata", 32'(rdv_seen), 32'd0);
    check("stale_no_done", 32'(done_cnt), 32'd0);

    // Randomized bursts against the reference memory.
    for (int n = 0; n < 30; n++) begin
      set_port($urandom_range(0, 3), 1'b0, 1, 3, $urandom_range(0, 50));
      base = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 7) == 0) base = 32'hFE0 + (32'($urandom_range(0, 7)) << 2);
      len = $urandom_range(0, 16);
      we  = 1'($urandom_range(0, 1));
      e   = 1'b0;
      for (int k = 0; k < len; k++) if (!legal(base + 32'(4 * k))) e = 1'b1;
      run_burst(base, len, we, 1'b0, e, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
